// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial accelerator.
// Status bit positions are consumed by the bus wrapper.
package fact_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int N_W_DEF   = 4;
    localparam int MAX_N_DEF = 12;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_BUSY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    function automatic logic [2:0] pack_status(
        input logic done,
        input logic err,
        input logic busy
    );
        logic [2:0] s;
        s = '0;
        s[STAT_DONE] = done;
        s[STAT_ERR]  = err;
        s[STAT_BUSY] = busy;
        return s;
    endfunction

endpackage

// File: rtl/fact_if.sv
// Request/status bundle between the bus wrapper and the factorial engine.
// master = wrapper side, slave = engine side.
interface fact_if #(
    parameter int WIDTH = 32,
    parameter int N_W   = 4
);
    logic             go;
    logic [N_W-1:0]   n;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output go, n,
        input  busy, done, err, result
    );

    modport slave (
        input  go, n,
        output busy, done, err, result
    );
endinterface

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, running product and single-cycle multiply.
// last_o flags the final iteration so the FSM can latch the product.
module fact_dp #(
    parameter int WIDTH = 32,
    parameter int N_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [N_W-1:0]   n_i,
    output logic             last_o,
    output logic [WIDTH-1:0] prod_o
);

    logic [N_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_q, prod_d;

    always_comb begin
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (load_i) begin
            cnt_d  = n_i;
            prod_d = WIDTH'(1);
        end else if (step_i) begin
            // low WIDTH bits of the full product are kept
            prod_d = prod_q * WIDTH'(cnt_q);
            cnt_d  = cnt_q - N_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

    assign last_o = (cnt_q <= N_W'(1));
    assign prod_o = prod_q;

endmodule

// File: rtl/fact_ctrl.sv
// Factorial sequencer: accepts go/n, drives fact_dp one multiply per clock,
// and holds sticky done/err status plus the last result.
module fact_ctrl
    import fact_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_W   = N_W_DEF,
    parameter int MAX_N = MAX_N_DEF
) (
    input logic clk,
    input logic rst,
    fact_if.slave bus
);

    localparam logic [N_W-1:0] MAX_NV = N_W'(MAX_N);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, step, last;
    logic [WIDTH-1:0] prod;

    fact_dp #(
        .WIDTH (WIDTH),
        .N_W   (N_W)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .n_i    (bus.n),
        .last_o (last),
        .prod_o (prod)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.go) begin
                    if (bus.n > MAX_NV) begin
                        state_d  = ERR;
                        result_d = '0;
                    end else begin
                        load    = 1'b1;
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                // go is deliberately not looked at here
                if (last) begin
                    result_d = prod;
                    state_d  = DONE;
                end else begin
                    step = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == MULT);
    assign bus.done   = (state_q == DONE);
    assign bus.err    = (state_q == ERR);
    assign bus.result = result_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// Self-checking bench for fact_ctrl; expected results come from a
// reference factorial pushed to a scoreboard at each accepted go.
module tb_fact_ctrl;

    logic clk;
    logic rst;

    fact_if #(.WIDTH(32), .N_W(4)) bus ();

    fact_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint res;
        int     lat;
        bit     is_err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void push_exp(input int nv);
        exp_t e;
        longint f;
        f = 1;
        if (nv > 12) begin
            e.res    = 0;
            e.lat    = 0;
            e.is_err = 1'b1;
        end else begin
            for (int i = 2; i <= nv; i++) f = f * i;
            e.res    = f;
            e.lat    = (nv < 1) ? 1 : nv;
            e.is_err = 1'b0;
        end
        sb.push_back(e);
    endfunction

    // drive go for exactly one accepting edge; returns at edge+1
    task automatic accept(input logic [3:0] nv);
        @(negedge clk);
        bus.n  = nv;
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int start_edges);
        exp_t        e;
        int          edges;
        bit          ok;
        logic [31:0] r0;
        logic [31:0] rexp;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s sb_empty: no expected entry", tag);
            return;
        end
        e     = sb.pop_front();
        rexp  = e.res[31:0];
        edges = start_edges;
        ok    = 1'b1;
        r0    = bus.result;
        while (!bus.done && !bus.err && edges < 50) begin
            if (bus.busy !== 1'b1 || bus.result !== r0) ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        n_cmp++;
        if (edges !== e.lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, edges, e.lat);
        end
        n_cmp++;
        if (bus.result !== rexp) begin
            n_bad++;
            $display("FAIL %s result: got %0d want %0d", tag, bus.result, rexp);
        end
        n_cmp++;
        if (bus.done !== !e.is_err || bus.err !== e.is_err) begin
            n_bad++;
            $display("FAIL %s flags: done=%b err=%b want done=%b err=%b",
                     tag, bus.done, bus.err, !e.is_err, e.is_err);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_end: got %b want 0", tag, bus.busy);
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_stable: got %b want 1", tag, ok);
        end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s flags: busy=%b done=%b err=%b want 000",
                     tag, bus.busy, bus.done, bus.err);
        end
        n_cmp++;
        if (bus.result !== 32'd0) begin
            n_bad++;
            $display("FAIL %s result: got %0d want 0", tag, bus.result);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        bus.go = 1'b0;
        bus.n  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("reset");
    endtask

    task automatic test_basic();
        push_exp(5);
        accept(4'd5);
        finish_job("n5", 0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.result !== 32'd120) begin
            n_bad++;
            $display("FAIL n5_hold: done=%b result=%0d want 1/120",
                     bus.done, bus.result);
        end
    endtask

    task automatic test_small();
        push_exp(0);
        accept(4'd0);
        finish_job("n0", 0);
        push_exp(1);
        accept(4'd1);
        finish_job("n1", 0);
        push_exp(12);
        accept(4'd12);
        finish_job("n12", 0);
    endtask

    task automatic test_error();
        push_exp(13);
        accept(4'd13);
        finish_job("n13", 0);
        push_exp(15);
        accept(4'd15);
        finish_job("n15", 0);
        push_exp(3);
        accept(4'd3);
        finish_job("n3_after_err", 0);
    endtask

    task automatic test_ignore_go();
        push_exp(10);
        accept(4'd10);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.n  = 4'd2;
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        finish_job("n10_ignore", 3);
    endtask

    task automatic test_reset_async();
        push_exp(7);
        accept(4'd7);
        finish_job("n7", 0);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_from_done");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        push_exp(9);
        accept(4'd9);
        finish_job("n9", 0);
        accept(4'd12);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_zero("abort_mid");
        @(negedge clk);
        rst = 1'b1;
        push_exp(4);
        accept(4'd4);
        finish_job("n4_after_abort", 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_error();
        test_ignore_go();
        test_reset_async();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
Sequencer and datapath for the memory-mapped factorial accelerator in the single-cycle SoC. It accepts a start pulse and a 4-bit operand n, then computes n! by iterated multiply-and-decrement, one multiply per clock. It reports busy, done and error status to the bus-interface wrapper and GPIO.

Parameters:
WIDTH, 32, result/product width in bits
N_W, 4, operand width in bits
MAX_N, 12, largest n whose factorial fits in WIDTH; n > MAX_N is an error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
go  input  1  start request, sampled on the rising edge of clk
n  input  N_W  operand, captured on the edge that accepts go
busy  output  1  high while the computation is in progress
done  output  1  sticky; high after a successful computation until the next accepted go
err  output  1  sticky; high after an n > MAX_N request until the next accepted go
result  output  WIDTH  n! when done=1; 0 when err=1; otherwise holds the last value

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, err=0, result=0, cnt=0, prod=0. Reset that arrives mid-computation aborts the computation. No partial result survives.
- States: IDLE, MULT, DONE, ERR. busy=1 only in MULT. done=1 only in DONE. err=1 only in ERR.
- go is accepted in IDLE, DONE and ERR. go in MULT is ignored: no restart and n is not recaptured.
- On an accepted go, if n > MAX_N: next state=ERR and result<=0. No MULT cycles occur.
- On an accepted go, if n <= MAX_N: cnt<=n, prod<=1, next state=MULT. done and err clear on the same edge.
- In MULT, each edge:
  - if cnt <= 1: result<=prod, next state=DONE
  - else: prod<=prod*cnt truncated to WIDTH bits, cnt<=cnt-1
- Latency: done rises max(n,1) clock edges after the edge that accepted go.
  - n=0: result=1 after 1 edge.
  - n=1: result=1 after 1 edge.
  - n=5: result=120 after 5 edges.
- Error latency: err rises on the edge that accepts go.
- A go held high continuously in DONE or ERR restarts the computation on every accepting edge. Software must pulse go.
- result changes only on entry to DONE or ERR, or on reset. It is stable for the entire busy period.
- The multiply is combinational within one cycle: WIDTH x WIDTH product, low WIDTH bits kept. For n <= MAX_N no truncation occurs.

Decomposition:
- Shared package fact_pkg holds:
  - state encoding: IDLE=2'd0, MULT=2'd1, DONE=2'd2, ERR=2'd3
  - MAX_N and WIDTH defaults
  - status bit positions for the bus wrapper: done=bit0, err=bit1, busy=bit2
- Sub-module fact_dp holds cnt, prod, the multiplier and the cnt<=1 compare. It takes load/step controls from the fact_ctrl FSM and returns last=(cnt<=1).

Test Plan:
- Reset: rst=0 for 1 cycle, then release -> busy=0, done=0, err=0, result=0. Asserting rst asynchronously between edges clears outputs immediately.
- n=5, go pulsed 1 cycle -> busy=1 for 5 cycles, then done=1, result=120 (0x78). Values stay stable with go low.
- n=0 and n=1, each go pulsed -> done=1 after 1 edge, result=1. Then n=12 -> done after 12 edges, result=479001600 (0x1C8CFC00).
- n=13, then n=15 -> err=1, done=0, busy=0, result=0 on the accepting edge. A following go with n=3 clears err; done=1 with result=6 after 3 edges.
- Start n=10, then pulse go with n=2 on the 3rd busy cycle -> the second go is ignored; done after 10 edges with result=3628800.
- Start n=12, assert rst=0 on the 6th busy cycle -> all outputs return to reset values at once. After release, go with n=4 -> result=24 after 4 edges.
